ext_addr_map_unit: RTL and testbench

- Runtime-programmable successor to the static external-crossbar address-rule table.
- Holds N_RULES address windows `{start, end, idx, en}`, writable through a simple config port.
- Decodes a stream of addresses through a one-stage valid/ready pipeline and returns the target slave index, a hit flag and a saturating miss counter.
- Sits in front of the external crossbar / peripheral slave encoder, replacing the fixed rule package for multi-accelerator builds.

---
 rtl/ext_addr_map_unit.sv | 165 ++++++++++++++++
 tb/tb_ext_addr_map_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_addr_map_unit.sv
`default_nettype none
// ============================================================================
// Module   : ext_addr_map_unit
// Purpose  : Runtime-programmable address window table with a one-stage
//            valid/ready lookup pipeline and a saturating miss counter.
// Revision : 1.0 - initial release
// ============================================================================
module ext_addr_map_unit #(
  parameter int N_RULES     = 4,
  parameter int ADDR_W      = 32,
  parameter int IDX_W       = 2,
  parameter int DEFAULT_IDX = 0,
  parameter int MISS_CNT_W  = 16,
  parameter int CFG_AW      = $clog2(N_RULES*4+2)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_we_i,
  input  logic [CFG_AW-1:0]     cfg_addr_i,
  input  logic [ADDR_W-1:0]     cfg_wdata_i,
  output logic [ADDR_W-1:0]     cfg_rdata_o,
  output logic                  locked_o,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_W-1:0]     req_addr_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IDX_W-1:0]      rsp_idx_o,
  output logic                  rsp_hit_o,
  output logic [MISS_CNT_W-1:0] miss_cnt_o
);

  localparam logic [CFG_AW-1:0] c_lock_addr   = CFG_AW'(4*N_RULES);
  localparam logic [CFG_AW-1:0] c_miss_addr   = CFG_AW'(4*N_RULES+1);
  localparam logic [IDX_W-1:0]  c_default_idx = IDX_W'(DEFAULT_IDX);

  logic                    r_lock;
  logic [MISS_CNT_W-1:0]   r_miss_cnt;
  logic                    r_rsp_valid;
  logic [IDX_W-1:0]        r_rsp_idx;
  logic                    r_rsp_hit;

  logic [N_RULES-1:0]        w_match;
  logic [N_RULES-1:0]        w_first;
  logic [N_RULES*IDX_W-1:0]  w_idx_masked;
  logic [N_RULES*ADDR_W-1:0] w_rd_rule;
  logic                      w_hit;
  logic [IDX_W-1:0]          w_dec_idx;
  logic [ADDR_W-1:0]         w_rdata;
  logic                      w_req_ready;
  logic                      w_accept;
  logic                      w_rule_we;
  logic                      w_miss_clr;

  assign w_rule_we  = cfg_we_i && !r_lock;
  assign w_miss_clr = cfg_we_i && (cfg_addr_i == c_miss_addr);

  generate
    for (genvar r = 0; r < N_RULES; r++) begin : g_rule
      localparam logic [CFG_AW-1:0] c_start_addr = CFG_AW'(4*r);
      localparam logic [CFG_AW-1:0] c_end_addr   = CFG_AW'(4*r+1);
      localparam logic [CFG_AW-1:0] c_idx_addr   = CFG_AW'(4*r+2);
      localparam logic [CFG_AW-1:0] c_en_addr    = CFG_AW'(4*r+3);

      logic [ADDR_W-1:0] r_start;
      logic [ADDR_W-1:0] r_end;
      logic [IDX_W-1:0]  r_idx;
      logic              r_en;
      logic [ADDR_W-1:0] w_rd;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_start <= '0;
          r_end   <= '0;
          r_idx   <= '0;
          r_en    <= 1'b0;
        end else if (w_rule_we) begin
          if (cfg_addr_i == c_start_addr) r_start <= cfg_wdata_i;
          if (cfg_addr_i == c_end_addr)   r_end   <= cfg_wdata_i;
          if (cfg_addr_i == c_idx_addr)   r_idx   <= cfg_wdata_i[IDX_W-1:0];
          if (cfg_addr_i == c_en_addr)    r_en    <= cfg_wdata_i[0];
        end
      end

      // End is exclusive, so an empty or inverted window can never match.
      assign w_match[r] = r_en && (req_addr_i >= r_start) && (req_addr_i < r_end);
      assign w_idx_masked[r*IDX_W +: IDX_W] = {IDX_W{w_first[r]}} & r_idx;

      always_comb begin
        w_rd = '0;
        if (cfg_addr_i == c_start_addr) w_rd = r_start;
        if (cfg_addr_i == c_end_addr)   w_rd = r_end;
        if (cfg_addr_i == c_idx_addr)   w_rd = ADDR_W'(r_idx);
        if (cfg_addr_i == c_en_addr)    w_rd = ADDR_W'(r_en);
      end
      assign w_rd_rule[r*ADDR_W +: ADDR_W] = w_rd;
    end
  endgenerate

  // Isolate the lowest set match bit so the lowest-numbered rule wins.
  assign w_first = w_match & (~w_match + N_RULES'(1));
  assign w_hit   = |w_match;

  always_comb begin
    w_dec_idx = '0;
    for (int r = 0; r < N_RULES; r++) begin
      w_dec_idx = w_dec_idx | w_idx_masked[r*IDX_W +: IDX_W];
    end
    if (!w_hit) w_dec_idx = c_default_idx;
  end

  always_comb begin
    w_rdata = '0;
    for (int r = 0; r < N_RULES; r++) begin
      w_rdata = w_rdata | w_rd_rule[r*ADDR_W +: ADDR_W];
    end
    if (cfg_addr_i == c_lock_addr) w_rdata = ADDR_W'(r_lock);
    if (cfg_addr_i == c_miss_addr) w_rdata = ADDR_W'(r_miss_cnt);
  end

  assign w_req_ready = !r_rsp_valid || rsp_ready_i;
  assign w_accept    = req_valid_i && w_req_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lock <= 1'b0;
    end else if (cfg_we_i && (cfg_addr_i == c_lock_addr) && cfg_wdata_i[0]) begin
      r_lock <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_miss_cnt <= '0;
    end else if (w_miss_clr) begin
      r_miss_cnt <= '0;
    end else if (w_accept && !w_hit && (r_miss_cnt != {MISS_CNT_W{1'b1}})) begin
      r_miss_cnt <= r_miss_cnt + MISS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_idx   <= c_default_idx;
      r_rsp_hit   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_idx   <= w_dec_idx;
      r_rsp_hit   <= w_hit;
    end else if (rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign cfg_rdata_o = w_rdata;
  assign locked_o    = r_lock;
  assign req_ready_o = w_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_idx_o   = r_rsp_idx;
  assign rsp_hit_o   = r_rsp_hit;
  assign miss_cnt_o  = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ext_addr_map_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_addr_map_unit
// Purpose  : Scoreboard bench for ext_addr_map_unit (MISS_CNT_W = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_addr_map_unit;

  localparam int N_RULES = 4;
  localparam int ADDR_W  = 32;
  localparam int IDX_W   = 2;
  localparam int MCW     = 4;
  localparam int CFG_AW  = $clog2(N_RULES*4+2);

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [CFG_AW-1:0] cfg_addr;
  logic [ADDR_W-1:0] cfg_wdata;
  logic [ADDR_W-1:0] cfg_rdata;
  logic              locked;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDX_W-1:0]  rsp_idx;
  logic              rsp_hit;
  logic [MCW-1:0]    miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_miss = 0;
  logic [IDX_W:0] exp_q[$];

  ext_addr_map_unit #(
    .N_RULES(N_RULES), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
    .DEFAULT_IDX(0), .MISS_CNT_W(MCW), .CFG_AW(CFG_AW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .cfg_rdata_o(cfg_rdata), .locked_o(locked),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_idx_o(rsp_idx), .rsp_hit_o(rsp_hit), .miss_cnt_o(miss_cnt)
  );

  always #5 clk = ~clk;

  // Every response handshake pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      n_tests = n_tests + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL rsp_unexpected: got idx=%0d hit=%0b, required no response", rsp_idx, rsp_hit);
      end else begin
        logic [IDX_W:0] e;
        e = exp_q.pop_front();
        if ({rsp_idx, rsp_hit} !== e) begin
          n_fail = n_fail + 1;
          $display("FAIL rsp_data: got idx=%0d hit=%0b, required idx=%0d hit=%0b",
                   rsp_idx, rsp_hit, e[IDX_W:1], e[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = CFG_AW'(a); cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [IDX_W-1:0] ei, input logic eh);
    int waited;
    logic acc;
    req_valid = 1'b1; req_addr = a;
    exp_q.push_back({ei, eh});
    waited = 0; acc = 1'b0;
    while (!acc && waited < 20) begin
      @(negedge clk);
      acc = req_ready;
      tick();
      waited++;
    end
    req_valid = 1'b0;
    if (!acc) begin
      n_tests = n_tests + 1; n_fail = n_fail + 1;
      $display("FAIL send_timeout: got no accept, required accept of 0x%08h", a);
    end else if (!eh) begin
      exp_miss = (exp_miss == 15) ? 15 : exp_miss + 1;
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin tick(); waited++; end
    n_tests = n_tests + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: got %0d pending responses, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    cfg_addr = '0; #1;
    n_tests = n_tests + 1;
    if ({rsp_valid, req_ready, locked, rsp_hit} !== 4'b0100 || rsp_idx !== 2'd0 || miss_cnt !== 4'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_state: got v=%0b rdy=%0b lock=%0b hit=%0b idx=%0d miss=%0d, required 0 1 0 0 0 0",
               rsp_valid, req_ready, locked, rsp_hit, rsp_idx, miss_cnt);
    end
    n_tests = n_tests + 1;
    if (cfg_rdata !== 32'h0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_start0: got 0x%08h, required 0", cfg_rdata);
    end
  endtask

  task automatic test_default_miss();
    send(32'h2000_0000, 2'd0, 1'b0);
    n_tests = n_tests + 1;
    if (rsp_valid !== 1'b1 || miss_cnt !== 4'd1) begin
      n_fail = n_fail + 1;
      $display("FAIL first_miss: got valid=%0b miss=%0d, required valid=1 miss=1", rsp_valid, miss_cnt);
    end
    drain();
  endtask

  task automatic test_rule_match();
    cfg_write(0, 32'h2000_0000);
    cfg_write(1, 32'h2010_0000);
    cfg_write(2, 32'hFFFF_FFFD);
    cfg_write(3, 32'h1);
    cfg_addr = CFG_AW'(2); #1;
    n_tests = n_tests + 1;
    if (cfg_rdata !== 32'h1) begin
      n_fail = n_fail + 1;
      $display("FAIL idx_readback: got 0x%08h, required 0x00000001", cfg_rdata);
    end
    cfg_addr = CFG_AW'(1); #1;
    n_tests = n_tests + 1;
    if (cfg_rdata !== 32'h2010_0000) begin
      n_fail = n_fail + 1;
      $display("FAIL end_readback: got 0x%08h, required 0x20100000", cfg_rdata);
    end
    send(32'h2000_0000, 2'd1, 1'b1);
    send(32'h200F_FFFF, 2'd1, 1'b1);
    send(32'h2010_0000, 2'd0, 1'b0);
    send(32'h1FFF_FFFF, 2'd0, 1'b0);
    drain();
    n_tests = n_tests + 1;
    if (miss_cnt !== MCW'(exp_miss)) begin
      n_fail = n_fail + 1;
      $display("FAIL match_miss_cnt: got %0d, required %0d", miss_cnt, exp_miss);
    end
  endtask

  task automatic test_overlap();
    cfg_write(0, 32'h1000); cfg_write(1, 32'h2000); cfg_write(2, 32'd2); cfg_write(3, 32'd1);
    cfg_write(4, 32'h0);    cfg_write(5, 32'h3000); cfg_write(6, 32'd3); cfg_write(7, 32'd1);
    cfg_write(8, 32'h5000); cfg_write(9, 32'h5000); cfg_write(10, 32'd1); cfg_write(11, 32'd1);
    send(32'h1800, 2'd2, 1'b1);
    send(32'h2800, 2'd3, 1'b1);
    send(32'h5000, 2'd0, 1'b0);
    cfg_write(3, 32'd0);
    send(32'h1800, 2'd3, 1'b1);
    // Lookup in the same cycle as disabling rule1 sees the old table.
    cfg_we = 1'b1; cfg_addr = CFG_AW'(7); cfg_wdata = 32'd0;
    send(32'h1800, 2'd3, 1'b1);
    cfg_we = 1'b0;
    send(32'h1800, 2'd0, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    int base_miss;
    cfg_write(3, 32'd1);
    rsp_ready = 1'b0;
    send(32'h1800, 2'd2, 1'b1);
    base_miss = exp_miss;
    req_valid = 1'b1; req_addr = 32'h9000;
    exp_q.push_back({2'd0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests = n_tests + 1;
      if (rsp_valid !== 1'b1 || rsp_idx !== 2'd2 || rsp_hit !== 1'b1 || req_ready !== 1'b0 ||
          miss_cnt !== MCW'(base_miss)) begin
        n_fail = n_fail + 1;
        $display("FAIL stall_hold: got v=%0b idx=%0d hit=%0b rdy=%0b miss=%0d, required 1 2 1 0 %0d",
                 rsp_valid, rsp_idx, rsp_hit, req_ready, miss_cnt, base_miss);
      end
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    exp_miss = exp_miss + 1;
    send(32'h1000, 2'd2, 1'b1);
    drain();
    n_tests = n_tests + 1;
    if (miss_cnt !== MCW'(exp_miss)) begin
      n_fail = n_fail + 1;
      $display("FAIL b2b_miss_cnt: got %0d, required %0d", miss_cnt, exp_miss);
    end
  endtask

  task automatic test_lock();
    cfg_write(16, 32'd1);
    cfg_write(0, 32'h0);
    cfg_write(16, 32'd0);
    cfg_addr = CFG_AW'(0); #1;
    n_tests = n_tests + 1;
    if (cfg_rdata !== 32'h1000 || locked !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL lock_hold: got start0=0x%08h locked=%0b, required 0x00001000 1", cfg_rdata, locked);
    end
    cfg_addr = CFG_AW'(18); #1;
    n_tests = n_tests + 1;
    if (cfg_rdata !== 32'h0) begin
      n_fail = n_fail + 1;
      $display("FAIL oor_read: got 0x%08h, required 0", cfg_rdata);
    end
    send(32'h9000, 2'd0, 1'b0);
    cfg_write(17, 32'h0);
    exp_miss = 0;
    drain();
    cfg_addr = CFG_AW'(17); #1;
    n_tests = n_tests + 1;
    if (miss_cnt !== 4'd0 || cfg_rdata !== 32'h0) begin
      n_fail = n_fail + 1;
      $display("FAIL locked_clear: got miss=%0d rd=%0d, required 0 0", miss_cnt, cfg_rdata);
    end
    rsp_ready = 1'b0;
    send(32'h1800, 2'd2, 1'b1);
    exp_q.delete();
    rst = 1'b1; tick(); rst = 1'b0;
    rsp_ready = 1'b1;
    exp_miss = 0;
    n_tests = n_tests + 1;
    if (locked !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL mid_reset: got lock=%0b v=%0b rdy=%0b, required 0 0 1", locked, rsp_valid, req_ready);
    end
  endtask

  task automatic test_miss_saturate();
    for (int i = 0; i < 20; i++) send(32'h4000 + 32'(i), 2'd0, 1'b0);
    n_tests = n_tests + 1;
    if (miss_cnt !== 4'd15) begin
      n_fail = n_fail + 1;
      $display("FAIL miss_sat: got %0d, required 15", miss_cnt);
    end
    cfg_we = 1'b1; cfg_addr = CFG_AW'(17); cfg_wdata = 32'h0;
    send(32'h7777, 2'd0, 1'b0);
    cfg_we = 1'b0;
    n_tests = n_tests + 1;
    if (miss_cnt !== 4'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL clear_wins: got %0d, required 0", miss_cnt);
    end
    send(32'h7778, 2'd0, 1'b0);
    n_tests = n_tests + 1;
    if (miss_cnt !== 4'd1) begin
      n_fail = n_fail + 1;
      $display("FAIL count_after_clear: got %0d, required 1", miss_cnt);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    test_reset();
    test_default_miss();
    test_rule_match();
    test_overlap();
    test_back_to_back();
    test_lock();
    test_miss_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
